// File: rtl/serial_port_ctrl.sv
// ---------------------------------------------------------------------------
// serial_port_ctrl
//
// Byte-wide CPU interface to an 8N1 UART. The transmitter and receiver run
// independently. Each uses a bit-time counter that wraps every CLKS_PER_BIT
// clock cycles.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (4 or more)
//
// Ports
//   clock         system clock; all state changes on its rising edge
//   reset         synchronous, active-high reset
//   s_rden        one-cycle pulse: the CPU has consumed the RX byte
//   s_wdata       byte to transmit
//   s_wren        one-cycle pulse: the CPU writes s_wdata
//   s_data_valid  an unread RX byte is held in s_data
//   s_data        the held RX byte
//   s_data_ready  the transmitter can accept a byte
//   uart_rxd      asynchronous serial input, idle high
//   uart_txd      serial output, idle high
//   rx_overrun    one-cycle pulse: an unread byte was overwritten
//   rx_frame_err  one-cycle pulse: the stop bit was sampled low
// ---------------------------------------------------------------------------
module serial_port_ctrl #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       s_rden,
    input  logic [7:0] s_wdata,
    input  logic       s_wren,
    output logic       s_data_valid,
    output logic [7:0] s_data,
    output logic       s_data_ready,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

    // Transmit state
    txState_t         txState_q;
    logic [CNT_W-1:0] txCnt_q;
    logic [CNT_W-1:0] txCnt_d;
    logic [2:0]       txBitIdx_q;
    logic [7:0]       txShift_q;
    logic             txd_q;
    logic             txReady_q;

    // Receive state
    rxState_t         rxState_q;
    logic [CNT_W-1:0] rxCnt_q;
    logic [CNT_W-1:0] rxCnt_d;
    logic [2:0]       rxBitIdx_q;
    logic [7:0]       rxShift_q;
    logic             rxErrWait_q;
    logic             rxSync1_q;
    logic             rxSync2_q;
    logic [7:0]       rxData_q;
    logic             rxValid_q;
    logic             rxOverrun_q;
    logic             rxFrameErr_q;

    assign txCnt_d = txCnt_q + CNT_W'(1);
    assign rxCnt_d = rxCnt_q + CNT_W'(1);

    // Transmitter FSM. uart_txd and s_data_ready are registered, so the line
    // drops to the start bit on the cycle after an accepted write. The shift
    // register presents the next data bit at bit 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            txState_q  <= TX_IDLE;
            txCnt_q    <= '0;
            txBitIdx_q <= '0;
            txShift_q  <= '0;
            txd_q      <= 1'b1;
            txReady_q  <= 1'b1;
        end else begin
            case (txState_q)
                TX_IDLE: begin
                    if (s_wren) begin
                        txShift_q  <= s_wdata;
                        txd_q      <= 1'b0;
                        txReady_q  <= 1'b0;
                        txCnt_q    <= '0;
                        txBitIdx_q <= '0;
                        txState_q  <= TX_START;
                    end
                end
                TX_START: begin
                    if (txCnt_q == BIT_LAST) begin
                        txCnt_q   <= '0;
                        txd_q     <= txShift_q[0];
                        txShift_q <= {1'b0, txShift_q[7:1]};
                        txState_q <= TX_DATA;
                    end else begin
                        txCnt_q <= txCnt_d;
                    end
                end
                TX_DATA: begin
                    if (txCnt_q == BIT_LAST) begin
                        txCnt_q <= '0;
                        if (txBitIdx_q == 3'd7) begin
                            txd_q     <= 1'b1;
                            txState_q <= TX_STOP;
                        end else begin
                            txd_q      <= txShift_q[0];
                            txShift_q  <= {1'b0, txShift_q[7:1]};
                            txBitIdx_q <= txBitIdx_q + 3'd1;
                        end
                    end else begin
                        txCnt_q <= txCnt_d;
                    end
                end
                TX_STOP: begin
                    if (txCnt_q == BIT_LAST) begin
                        txCnt_q   <= '0;
                        txReady_q <= 1'b1;
                        txState_q <= TX_IDLE;
                    end else begin
                        txCnt_q <= txCnt_d;
                    end
                end
                default: txState_q <= TX_IDLE;
            endcase
        end
    end

    // Receiver. The synchronizer flops reset high so that a reset does not
    // look like a start bit. After the start edge, the receiver waits half a
    // bit to reach the middle of the start bit. From there, each whole-bit
    // wait lands mid-bit. A low stop bit parks the FSM in RX_STOP until the
    // line returns high, so that a held-low line cannot restart reception.
    // A completion that coincides with a CPU read hands over the new byte
    // without flagging an overrun.
    always_ff @(posedge clock) begin
        if (reset) begin
            rxSync1_q    <= 1'b1;
            rxSync2_q    <= 1'b1;
            rxState_q    <= RX_IDLE;
            rxCnt_q      <= '0;
            rxBitIdx_q   <= '0;
            rxShift_q    <= '0;
            rxErrWait_q  <= 1'b0;
            rxData_q     <= '0;
            rxValid_q    <= 1'b0;
            rxOverrun_q  <= 1'b0;
            rxFrameErr_q <= 1'b0;
        end else begin
            rxSync1_q    <= uart_rxd;
            rxSync2_q    <= rxSync1_q;
            rxOverrun_q  <= 1'b0;
            rxFrameErr_q <= 1'b0;

            if (s_rden && rxValid_q) begin
                rxValid_q <= 1'b0;
            end

            case (rxState_q)
                RX_IDLE: begin
                    if (!rxSync2_q) begin
                        rxCnt_q    <= '0;
                        rxBitIdx_q <= '0;
                        rxState_q  <= RX_START;
                    end
                end
                RX_START: begin
                    if (rxCnt_q == HALF_LAST) begin
                        rxCnt_q   <= '0;
                        rxState_q <= rxSync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rxCnt_q <= rxCnt_d;
                    end
                end
                RX_DATA: begin
                    if (rxCnt_q == BIT_LAST) begin
                        rxCnt_q   <= '0;
                        rxShift_q <= {rxSync2_q, rxShift_q[7:1]};
                        if (rxBitIdx_q == 3'd7) begin
                            rxState_q <= RX_STOP;
                        end else begin
                            rxBitIdx_q <= rxBitIdx_q + 3'd1;
                        end
                    end else begin
                        rxCnt_q <= rxCnt_d;
                    end
                end
                RX_STOP: begin
                    if (rxErrWait_q) begin
                        if (rxSync2_q) begin
                            rxErrWait_q <= 1'b0;
                            rxState_q   <= RX_IDLE;
                        end
                    end else if (rxCnt_q == BIT_LAST) begin
                        rxCnt_q <= '0;
                        if (rxSync2_q) begin
                            rxData_q    <= rxShift_q;
                            rxValid_q   <= 1'b1;
                            rxOverrun_q <= rxValid_q && !s_rden;
                            rxState_q   <= RX_IDLE;
                        end else begin
                            rxFrameErr_q <= 1'b1;
                            rxErrWait_q  <= 1'b1;
                        end
                    end else begin
                        rxCnt_q <= rxCnt_d;
                    end
                end
                default: rxState_q <= RX_IDLE;
            endcase
        end
    end

    assign uart_txd     = txd_q;
    assign s_data_ready = txReady_q;
    assign s_data       = rxData_q;
    assign s_data_valid = rxValid_q;
    assign rx_overrun   = rxOverrun_q;
    assign rx_frame_err = rxFrameErr_q;

endmodule

// File: doc/serial_port_ctrl.md
SERIAL_PORT_CTRL -- requirements
Module: serial_port_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (legal range >=4).
REQ-002 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port s_rden  input  1  one-cycle pulse: CPU consumed the RX byte.
REQ-005 SHALL have port s_wdata  input  8  byte to transmit.
REQ-006 SHALL have port s_wren  input  1  one-cycle pulse: CPU writes s_wdata.
REQ-007 SHALL have port s_data_valid  output  1  an unread RX byte is held.
REQ-008 SHALL have port s_data  output  8  held RX byte.
REQ-009 SHALL have port s_data_ready  output  1  TX can accept a byte.
REQ-010 SHALL have port uart_rxd  input  1  asynchronous serial input, idle high.
REQ-011 SHALL have port uart_txd  output  1  serial output, idle high.
REQ-012 SHALL have port rx_overrun  output  1  one-cycle pulse: unread byte overwritten.
REQ-013 SHALL have port rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-014 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each CLKS_PER_BIT cycles.
REQ-015 TX FSM SHALL have states TX_IDLE, TX_START, TX_DATA, TX_STOP; s_data_ready = 1 only in TX_IDLE.
REQ-016 s_wren with s_data_ready=1 SHALL latch s_wdata and enter TX_START; uart_txd goes 0 the following cycle.
REQ-017 s_wren with s_data_ready=0 SHALL be ignored (byte dropped, no state change).
REQ-018 TX_START, each of 8 TX_DATA bits and TX_STOP SHALL each hold uart_txd for exactly CLKS_PER_BIT cycles; after TX_STOP, return to TX_IDLE (total 10*CLKS_PER_BIT cycles busy).
REQ-019 uart_rxd SHALL pass through a 2-flop synchronizer before any use; RX logic sees only the synchronized value.
REQ-020 RX FSM SHALL have states RX_IDLE, RX_START, RX_DATA, RX_STOP.
REQ-021 RX_IDLE: synchronized rxd = 0 SHALL enter RX_START and zero the bit counter.
REQ-022 RX_START: after CLKS_PER_BIT/2 (integer division) cycles, rxd = 0 SHALL enter RX_DATA; rxd = 1 SHALL return to RX_IDLE (glitch rejected, no flags).
REQ-023 RX_DATA: SHALL sample rxd every CLKS_PER_BIT cycles (mid-bit), shifting LSB first; after 8th sample enter RX_STOP.
REQ-024 RX_STOP: mid-bit sample = 1 SHALL write s_data, set s_data_valid next cycle, return to RX_IDLE.
REQ-025 RX_STOP: mid-bit sample = 0 SHALL discard the byte, pulse rx_frame_err one cycle, leave s_data/s_data_valid unchanged, and return to RX_IDLE only after rxd = 1.
REQ-026 s_rden with s_data_valid = 1 SHALL clear s_data_valid next cycle; s_rden with s_data_valid = 0 SHALL be ignored.
REQ-027 Byte completion while s_data_valid = 1 and s_rden = 0 SHALL overwrite s_data, keep s_data_valid = 1, pulse rx_overrun.
REQ-028 Byte completion coincident with s_rden SHALL leave s_data_valid = 1 with the new byte and SHALL NOT pulse rx_overrun.
REQ-029 TX and RX SHALL operate fully independently and concurrently.
REQ-030 Bit-time counters SHALL be wide enough for CLKS_PER_BIT-1 and wrap to 0 at each bit boundary.

Reset
REQ-031 On reset: both FSMs idle, counters 0, uart_txd = 1, s_data_ready = 1, s_data_valid = 0, s_data = 8'h00, rx_overrun = 0, rx_frame_err = 0, synchronizer flops = 1.
REQ-032 Reset asserted mid-frame SHALL abort TX/RX; uart_txd = 1 the cycle after the reset edge; partial RX byte discarded.

Verification (CLKS_PER_BIT = 4)
REQ-033 s_wren, s_wdata=8'hA5 -> s_data_ready=0 next cycle; txd = 0,1,0,1,0,0,1,0,1,1 each 4 cycles; ready=1 after 40 cycles.
REQ-034 Second s_wren (8'h3C) during 8'hA5 frame -> ignored; only A5 transmitted.
REQ-035 Drive rxd frame 8'h5A -> s_data_valid=1, s_data=8'h5A; s_rden -> valid=0 next cycle.
REQ-036 Frames 8'h11 then 8'h22 with no s_rden -> rx_overrun pulses once, s_data=8'h22, valid=1; repeat with s_rden at completion cycle -> no pulse.
REQ-037 Frame with stop bit 0 -> rx_frame_err pulses once, valid stays 0; 1-cycle low glitch on idle rxd -> no byte, no flags.
REQ-038 Reset during TX data bit 3 -> txd=1, ready=1 next cycle; new s_wren 8'hFF then transmits cleanly.
